// File: rtl/xif_coproc_alu.sv
// Single-outstanding CORE-V-XIF coprocessor for custom-0 MUL/MINU (plus ACC/ACLR).
// Define XIF_COPROC_ACC_EN to build the accumulator and decode ACC/ACLR.
module xif_coproc_alu #(
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned MUL_LAT    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [31:0]           issue_instr_i,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  input  logic [63:0]           issue_rs_i,
  input  logic [1:0]            issue_rs_valid_i,
  output logic                  issue_accept_o,
  output logic                  issue_writeback_o,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [X_ID_WIDTH-1:0] result_id_o,
  output logic [31:0]           result_data_o,
  output logic [4:0]            result_rd_o,
  output logic                  result_we_o
);

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [2:0] F3_MUL      = 3'b000;
  localparam logic [2:0] F3_ACC      = 3'b001;
  localparam logic [2:0] F3_ACLR     = 3'b010;
  localparam logic [2:0] F3_MINU     = 3'b011;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_COMMIT,
    EXEC,
    RESULT
  } state_t;

  state_t state_q, state_n;

  logic [X_ID_WIDTH-1:0] id_q;
  logic [2:0]            op_q;
  logic [4:0]            rd_q;
  logic [31:0]           rs1_q, rs2_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [2:0]  issue_f3;
  logic        matched;
  logic        issue_hs;
  logic        commit_hit;
  logic [2:0]  op_src;
  logic        enter_exec;
  logic        exec_last;
  logic [31:0] prod;
  logic [31:0] exec_res;

`ifdef XIF_COPROC_ACC_EN
  logic [31:0] acc_q;
  logic [31:0] acc_n;
`endif

  // Register-index fields are unused: operands arrive by value on issue_rs_i.
  logic unused_instr_bits;
  assign unused_instr_bits = ^issue_instr_i[24:15];

  // Decode
  always_comb begin
    issue_f3 = issue_instr_i[14:12];
    matched  = 1'b0;
    if (issue_instr_i[6:0] == OPC_CUSTOM0 && issue_instr_i[31:25] == 7'd0) begin
      case (issue_f3)
        F3_MUL, F3_MINU: matched = 1'b1;
`ifdef XIF_COPROC_ACC_EN
        F3_ACC, F3_ACLR: matched = 1'b1;
`endif
        default:         matched = 1'b0;
      endcase
    end
  end

  assign issue_ready_o     = (state_q == IDLE) && (!matched || issue_rs_valid_i == 2'b11);
  assign issue_accept_o    = matched;
  assign issue_writeback_o = matched;
  assign issue_hs          = issue_valid_i && issue_ready_o && matched;

  // In IDLE a commit can only refer to the instruction being issued this cycle.
  always_comb begin
    commit_hit = 1'b0;
    op_src     = op_q;
    if (state_q == IDLE) begin
      commit_hit = issue_hs && commit_valid_i && (commit_id_i == issue_id_i);
      op_src     = issue_f3;
    end else if (state_q == WAIT_COMMIT) begin
      commit_hit = commit_valid_i && (commit_id_i == id_q);
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: begin
        if (issue_hs) begin
          if (commit_hit) state_n = commit_kill_i ? IDLE : EXEC;
          else            state_n = WAIT_COMMIT;
        end
      end
      WAIT_COMMIT: begin
        if (commit_hit) state_n = commit_kill_i ? IDLE : EXEC;
      end
      EXEC: begin
        if (cnt_q == '0) state_n = RESULT;
      end
      RESULT: begin
        if (result_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign enter_exec = (state_q != EXEC) && (state_n == EXEC);
  assign exec_last  = (state_q == EXEC) && (cnt_q == '0);
  assign prod       = rs1_q * rs2_q;

  always_comb begin
    exec_res = '0;
`ifdef XIF_COPROC_ACC_EN
    acc_n    = acc_q;
`endif
    case (op_q)
      F3_MUL:  exec_res = prod;
      F3_MINU: exec_res = (rs1_q < rs2_q) ? rs1_q : rs2_q;
`ifdef XIF_COPROC_ACC_EN
      F3_ACC: begin
        acc_n    = acc_q + rs1_q + rs2_q;
        exec_res = acc_n;
      end
      F3_ACLR: begin
        exec_res = acc_q;
        acc_n    = '0;
      end
`endif
      default: exec_res = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_q           <= '0;
      op_q           <= '0;
      rd_q           <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      cnt_q          <= '0;
      result_valid_o <= 1'b0;
      result_id_o    <= '0;
      result_data_o  <= '0;
      result_rd_o    <= '0;
      result_we_o    <= 1'b0;
`ifdef XIF_COPROC_ACC_EN
      acc_q          <= '0;
`endif
    end else begin
      if (state_q == IDLE && issue_hs) begin
        id_q  <= issue_id_i;
        op_q  <= issue_f3;
        rd_q  <= issue_instr_i[11:7];
        rs1_q <= issue_rs_i[31:0];
        rs2_q <= issue_rs_i[63:32];
      end
      // Counter holds remaining EXEC cycles minus one; zero marks the last cycle.
      if (enter_exec) begin
        cnt_q <= (op_src == F3_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
      end else if (state_q == EXEC && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (exec_last) begin
        result_valid_o <= 1'b1;
        result_we_o    <= 1'b1;
        result_id_o    <= id_q;
        result_rd_o    <= rd_q;
        result_data_o  <= exec_res;
`ifdef XIF_COPROC_ACC_EN
        acc_q          <= acc_n;
`endif
      end
      if (state_q == RESULT && result_ready_i) begin
        result_valid_o <= 1'b0;
        result_we_o    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xif_coproc_alu.sv
// Directed self-checking bench for xif_coproc_alu (MUL_LAT=2); ACC vectors run
// only when XIF_COPROC_ACC_EN is defined.
module tb_xif_coproc_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_instr;
  logic [3:0]  issue_id;
  logic [63:0] issue_rs;
  logic [1:0]  issue_rs_valid;
  logic        issue_accept;
  logic        issue_writeback;
  logic        commit_valid;
  logic [3:0]  commit_id;
  logic        commit_kill;
  logic        result_valid;
  logic        result_ready;
  logic [3:0]  result_id;
  logic [31:0] result_data;
  logic [4:0]  result_rd;
  logic        result_we;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  xif_coproc_alu #(.X_ID_WIDTH(4), .MUL_LAT(2)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .issue_valid_i     (issue_valid),
    .issue_ready_o     (issue_ready),
    .issue_instr_i     (issue_instr),
    .issue_id_i        (issue_id),
    .issue_rs_i        (issue_rs),
    .issue_rs_valid_i  (issue_rs_valid),
    .issue_accept_o    (issue_accept),
    .issue_writeback_o (issue_writeback),
    .commit_valid_i    (commit_valid),
    .commit_id_i       (commit_id),
    .commit_kill_i     (commit_kill),
    .result_valid_o    (result_valid),
    .result_ready_i    (result_ready),
    .result_id_o       (result_id),
    .result_data_o     (result_data),
    .result_rd_o       (result_rd),
    .result_we_o       (result_we)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {7'd0, 10'd0, f3, rd, 7'b0001011};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a matched issue at the current negedge, optionally with a same-cycle commit/kill.
  task automatic drive_issue(input logic [31:0] instr, input logic [3:0] id,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic cv, input logic kill, input string tag);
    issue_valid    = 1'b1;
    issue_instr    = instr;
    issue_id       = id;
    issue_rs       = {b, a};
    issue_rs_valid = 2'b11;
    commit_valid   = cv;
    commit_id      = id;
    commit_kill    = kill;
    #1;
    check({tag, "_iss_ready"}, {31'd0, issue_ready}, 32'd1);
    check({tag, "_iss_accept"}, {31'd0, issue_accept}, 32'd1);
    tick();
    issue_valid  = 1'b0;
    issue_instr  = '0;
    commit_valid = 1'b0;
    commit_kill  = 1'b0;
  endtask

  // Issue with commit at issue; result expected lat cycles after the commit cycle.
  task automatic run_op(input logic [2:0] f3, input logic [4:0] rd, input logic [3:0] id,
                        input logic [31:0] a, input logic [31:0] b,
                        input int unsigned lat, input logic [31:0] exp, input string tag);
    drive_issue(mk(f3, rd), id, a, b, 1'b1, 1'b0, tag);
    for (int unsigned i = 1; i < lat; i++) begin
      check({tag, "_early_valid"}, {31'd0, result_valid}, 32'd0);
      check({tag, "_busy_ready"}, {31'd0, issue_ready}, 32'd0);
      tick();
    end
    check({tag, "_valid"}, {31'd0, result_valid}, 32'd1);
    check({tag, "_data"}, result_data, exp);
    check({tag, "_id"}, {28'd0, result_id}, {28'd0, id});
    check({tag, "_rd"}, {27'd0, result_rd}, {27'd0, rd});
    check({tag, "_we"}, {31'd0, result_we}, 32'd1);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check({tag, "_done_valid"}, {31'd0, result_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'd0, issue_ready}, 32'd1);
  endtask

  initial begin
    rst            = 1'b1;
    issue_valid    = 1'b0;
    issue_instr    = '0;
    issue_id       = '0;
    issue_rs       = '0;
    issue_rs_valid = 2'b00;
    commit_valid   = 1'b0;
    commit_id      = '0;
    commit_kill    = 1'b0;
    result_ready   = 1'b0;
    tick();
    tick();
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_data", result_data, 32'd0);
    check("rst_id", {28'd0, result_id}, 32'd0);
    check("rst_rd", {27'd0, result_rd}, 32'd0);
    check("rst_we", {31'd0, result_we}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_ready", {31'd0, issue_ready}, 32'd1);

    // MUL committed at issue: valid at C+3
    run_op(3'b000, 5'd5, 4'd3, 32'd7, 32'd6, 3, 32'd42, "mul7x6");
    run_op(3'b000, 5'd31, 4'd9, 32'hFFFF_FFFF, 32'd2, 3, 32'hFFFF_FFFE, "mul_wrap");
    run_op(3'b011, 5'd1, 4'd2, 32'd9, 32'd3, 2, 32'd3, "minu9_3");

    // MINU committed 4 cycles after issue
    drive_issue(mk(3'b011, 5'd12), 4'd4, 32'hFFFF_FFFF, 32'd5, 1'b0, 1'b0, "minu_late");
    for (int unsigned i = 0; i < 3; i++) begin
      check("minu_late_wait_ready", {31'd0, issue_ready}, 32'd0);
      check("minu_late_wait_valid", {31'd0, result_valid}, 32'd0);
      tick();
    end
    commit_valid = 1'b1;
    commit_id    = 4'd4;
    #1;
    check("minu_late_commit_ready", {31'd0, issue_ready}, 32'd0);
    tick();
    commit_valid = 1'b0;
    check("minu_late_c1_valid", {31'd0, result_valid}, 32'd0);
    check("minu_late_c1_ready", {31'd0, issue_ready}, 32'd0);
    tick();
    check("minu_late_valid", {31'd0, result_valid}, 32'd1);
    check("minu_late_data", result_data, 32'd5);
    check("minu_late_rd", {27'd0, result_rd}, 32'd12);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("minu_late_done", {31'd0, result_valid}, 32'd0);

    // Kill after a foreign-id commit is ignored
    drive_issue(mk(3'b011, 5'd7), 4'd1, 32'd1, 32'd2, 1'b0, 1'b0, "kill");
    commit_valid = 1'b1;
    commit_id    = 4'd2;
    commit_kill  = 1'b0;
    tick();
    commit_valid = 1'b0;
    check("kill_other_id_ready", {31'd0, issue_ready}, 32'd0);
    check("kill_other_id_valid", {31'd0, result_valid}, 32'd0);
    commit_valid = 1'b1;
    commit_id    = 4'd1;
    commit_kill  = 1'b1;
    tick();
    commit_valid = 1'b0;
    commit_kill  = 1'b0;
    check("kill_idle_ready", {31'd0, issue_ready}, 32'd1);
    for (int unsigned i = 0; i < 3; i++) begin
      check("kill_no_result", {31'd0, result_valid}, 32'd0);
      tick();
    end

    // Kill in the issue cycle: straight back to IDLE
    drive_issue(mk(3'b000, 5'd3), 4'd6, 32'd3, 32'd3, 1'b1, 1'b1, "kill_at_issue");
    check("kill_at_issue_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    check("kill_at_issue_valid", {31'd0, result_valid}, 32'd0);

    // Operand readiness and unmatched encodings
    issue_valid    = 1'b1;
    issue_instr    = mk(3'b011, 5'd4);
    issue_rs_valid = 2'b01;
    #1;
    check("rsv01_ready", {31'd0, issue_ready}, 32'd0);
    check("rsv01_accept", {31'd0, issue_accept}, 32'd1);
    issue_rs_valid = 2'b11;
    issue_instr    = 32'h0000_0033;
    #1;
    check("noncustom_ready", {31'd0, issue_ready}, 32'd1);
    check("noncustom_accept", {31'd0, issue_accept}, 32'd0);
    check("noncustom_wb", {31'd0, issue_writeback}, 32'd0);
    issue_instr = mk(3'b100, 5'd4);
    #1;
    check("f3_100_accept", {31'd0, issue_accept}, 32'd0);
    issue_instr = mk(3'b000, 5'd4) | 32'h0200_0000;
    #1;
    check("funct7_accept", {31'd0, issue_accept}, 32'd0);
`ifndef XIF_COPROC_ACC_EN
    issue_instr = mk(3'b001, 5'd4);
    #1;
    check("noacc_acc_accept", {31'd0, issue_accept}, 32'd0);
`endif
    issue_instr = 32'h0000_0033;
    tick();
    check("unmatched_stays_idle", {31'd0, issue_ready}, 32'd1);
    issue_valid = 1'b0;
    issue_instr = '0;
    tick();
    check("unmatched_no_result", {31'd0, result_valid}, 32'd0);

    // Backpressure: 5 cycles stalled, handshake in the 6th
    drive_issue(mk(3'b000, 5'd9), 4'd5, 32'h0001_0000, 32'h0001_0001, 1'b1, 1'b0, "bp");
    tick();
    tick();
    for (int unsigned i = 0; i < 5; i++) begin
      check("bp_hold_valid", {31'd0, result_valid}, 32'd1);
      check("bp_hold_data", result_data, 32'h0001_0000);
      check("bp_hold_id", {28'd0, result_id}, 32'd5);
      check("bp_hold_ready", {31'd0, issue_ready}, 32'd0);
      tick();
    end
    result_ready = 1'b1;
    #1;
    check("bp_6th_valid", {31'd0, result_valid}, 32'd1);
    tick();
    result_ready = 1'b0;
    check("bp_after_valid", {31'd0, result_valid}, 32'd0);
    // Back-to-back issue right after the handshake
    run_op(3'b011, 5'd2, 4'd7, 32'd100, 32'd200, 2, 32'd100, "b2b_minu");

    // Reset during EXEC drops the instruction
    drive_issue(mk(3'b000, 5'd8), 4'd8, 32'd11, 32'd11, 1'b1, 1'b0, "rst_exec");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      check("rst_exec_no_result", {31'd0, result_valid}, 32'd0);
      tick();
    end
    check("rst_exec_idle", {31'd0, issue_ready}, 32'd1);

`ifdef XIF_COPROC_ACC_EN
    run_op(3'b001, 5'd10, 4'd1, 32'hFFFF_FFFF, 32'd1, 2, 32'd0, "acc_wrap");
    run_op(3'b001, 5'd10, 4'd2, 32'd3, 32'd4, 2, 32'd7, "acc_3_4");
    run_op(3'b010, 5'd11, 4'd3, 32'd0, 32'd0, 2, 32'd7, "aclr");
    run_op(3'b001, 5'd10, 4'd4, 32'd0, 32'd0, 2, 32'd0, "acc_after_clr");
    run_op(3'b001, 5'd10, 4'd5, 32'd20, 32'd0, 2, 32'd20, "acc_load20");
    drive_issue(mk(3'b001, 5'd10), 4'd6, 32'd5, 32'd0, 1'b1, 1'b0, "acc_rst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("acc_rst_no_result", {31'd0, result_valid}, 32'd0);
    run_op(3'b001, 5'd10, 4'd7, 32'd0, 32'd0, 2, 32'd0, "acc_zero_after_rst");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xif_coproc_alu.md
# xif_coproc_alu

Single-outstanding CORE-V-XIF coprocessor: the responder end of the issue, commit and result interfaces that the cv32e40px CPU drives. It accepts custom-0 instructions, waits for commit or kill, executes a small integer op set (multi-cycle multiply, optional accumulator) and returns the rd writeback over the result interface. It sits beside the CPU wrapper in core-v-mini-mcu and connects to its XIF issue, commit and result signals. Compressed, memory and memory-result interfaces are not used by this block.

## Interface
- X_ID_WIDTH, 4, width of instruction id
- MUL_LAT, 2, EXEC cycles for MUL (legal range 1..15)
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- issue_valid_i  in  1  issue request valid
- issue_ready_o  out  1  issue request ready
- issue_instr_i  in  32  instruction word
- issue_id_i  in  X_ID_WIDTH  instruction id
- issue_rs_i  in  64  {rs2, rs1}, rs1 in [31:0]
- issue_rs_valid_i  in  2  operand valid bits, [0]=rs1
- issue_accept_o  out  1  instruction is offloaded here
- issue_writeback_o  out  1  instruction writes rd
- commit_valid_i  in  1  commit transaction valid
- commit_id_i  in  X_ID_WIDTH  id being committed or killed
- commit_kill_i  in  1  1 = kill, 0 = commit
- result_valid_o  out  1  result valid
- result_ready_i  in  1  CPU ready for result
- result_id_o  out  X_ID_WIDTH  id of result
- result_data_o  out  32  rd value
- result_rd_o  out  5  destination register = instr[11:7]
- result_we_o  out  1  write enable, 1 for every emitted result

## Operation
- Decode: match when instr[6:0]=7'b0001011 and funct7=instr[31:25]=0. funct3: 000 MUL (low 32 bits of rs1*rs2, unsigned); 011 MINU (unsigned min); 001 ACC (acc <= acc+rs1+rs2, rd=new acc); 010 ACLR (rd=old acc, acc <= 0). Anything else is not matched.
- issue_ready_o = (state==IDLE) && (!matched || issue_rs_valid_i==2'b11). Combinational.
- issue_accept_o = issue_writeback_o = matched. Both are meaningful only when issue_valid_i && issue_ready_o. An unmatched instruction is acknowledged with accept=0 and is not stored.
- FSM states: IDLE, WAIT_COMMIT, EXEC, RESULT.
- IDLE: on an accepted handshake, latch id, funct3, rd, rs1 and rs2. If a commit for the same id arrives in the same cycle, branch on it as in WAIT_COMMIT. Otherwise go to WAIT_COMMIT.
- WAIT_COMMIT: on commit_valid_i && commit_id_i==latched id: kill goes to IDLE with no result and acc unchanged; commit goes to EXEC and loads the cycle counter. Commits for other ids are ignored.
- EXEC: the counter counts MUL_LAT cycles for MUL and 1 cycle otherwise. In the last cycle, register result_data and update acc, then go to RESULT.
- RESULT: result_valid_o=1 and the outputs are held stable until result_ready_i. Then go to IDLE. result_valid_o never drops without a handshake.
- Arithmetic is modulo 2^32. ACC wraps silently; 0xFFFFFFFF+1+0 gives 0.
- Only one instruction is in flight, so issue_ready_o=0 in every non-IDLE state.

## Timing
- Reset values: state IDLE, result_valid_o 0, result_id_o/result_data_o/result_rd_o 0, result_we_o 0, acc 0, counter 0.
- issue_ready_o, issue_accept_o and issue_writeback_o are combinational. All result_* outputs are registered.
- Latency is measured from the commit cycle C, including a commit in the issue cycle. result_valid_o rises at C+2 for 1-cycle ops and at C+1+MUL_LAT for MUL.
- Back-to-back: the cycle after the result handshake is IDLE, where a new issue can be acknowledged. Minimum issue-to-issue spacing is 3 cycles for 1-cycle ops committed at issue.
- Reset mid-operation (any state): the in-flight instruction is dropped and no result is emitted. acc returns to 0.
- A kill in the issue cycle means no WAIT_COMMIT visit; the next cycle is IDLE.
- A commit_valid_i while in EXEC or RESULT is ignored.

## Configuration
- XIF_COPROC_ACC_EN defined: ACC and ACLR are decoded and the 32-bit acc register exists.
- Macro undefined: funct3 001/010 are unmatched (accept=0), no acc register is built, and only MUL/MINU are supported.

## Test plan
- MUL, MUL_LAT=2: rs1=7, rs2=6, id=3, commit at the issue cycle -> result_valid_o at C+3, data=42, id=3, rd=instr[11:7], we=1.
- MINU: rs1=0xFFFFFFFF, rs2=5, commit 4 cycles after issue -> data=5 at C+2. issue_ready_o=0 throughout.
- Kill: issue id=1, then kill id=1 -> no result_valid_o, back to IDLE. A commit for id=2 in WAIT_COMMIT is ignored.
- Operands not ready: custom-0 with rs_valid=2'b01 -> ready=0. Non-custom opcode -> ready=1, accept=0, writeback=0.
- Backpressure: result_ready_i held low for 5 cycles -> valid and data stable. Handshake in the 6th cycle, then IDLE.
- ACC (macro defined): ACC 0xFFFFFFFF+1 -> data 0. ACC 3+4 -> 7. ACLR -> 7, then ACC 0+0 -> 0. Reset mid-EXEC -> no result, acc=0.
